ir_prefetch_queue: RTL
======================

Name: ir_prefetch_queue

Overview:
- Instruction prefetch stage directly upstream of the write-back instruction register (IR).
- Fetches instruction words from program memory over a req/ack handshake into a small FIFO.
- Presents the head word to the IR with a one-cycle load strobe, which drives the IR's ClockEnable; the IR's D input is driven by ir_data.
- Flushes the FIFO and redirects fetch on a PC load (branch/jump).

Parameters:
- NrOfBits, 16, instruction word width.
- AddrBits, 12, program address width.
- Depth, 4, FIFO entries; power of two, at least 2.

Ports:
- Clock  in  1  system clock; all state changes on its rising edge.
- Reset  in  1  synchronous, active-low reset.
- Tick  in  1  global advance enable; state changes only on cycles with Tick=1, except Reset.
- pc_load  in  1  redirect request.
- pc_value  in  AddrBits  redirect target address.
- mem_req  out  1  memory read request.
- mem_addr  out  AddrBits  read address.
- mem_ack  in  1  read complete; mem_rdata is valid on this cycle.
- mem_rdata  in  NrOfBits  read data.
- ir_ready  in  1  IR stage can accept a word.
- ir_load  out  1  pop strobe; drives IR ClockEnable.
- ir_data  out  NrOfBits  head word.
- ir_pc  out  AddrBits  address of the head word.
- empty  out  1  FIFO empty.
- full  out  1  FIFO full.

Behaviour:
- Reset (Reset=0 at a rising edge):
  - FIFO pointers and count go to 0; empty=1, full=0.
  - fetch_pc=0, FSM=IDLE, mem_req=0, mem_addr=0.
  - ir_data=0, ir_pc=0.
  - Reset mid-transaction drops the request with no wait for ack; a later stray ack is ignored while in IDLE.
- FSM states:
  - IDLE: if Tick and count<Depth and !pc_load, go to REQ and drive mem_req=1, mem_addr=fetch_pc.
  - REQ: mem_req and mem_addr stay stable until a Tick cycle with mem_ack=1. On that cycle:
    - push {mem_rdata, mem_addr};
    - fetch_pc=mem_addr+1, wrapping modulo 2^AddrBits;
    - go to REQ at the new address if (count after push/pop)<Depth, else go to IDLE.
  - DISCARD: mem_req stays high at the old address. On ack, drop the data and go to REQ at fetch_pc.
- At most one request is outstanding at a time.
  - A request is issued only when a FIFO slot is free, so a push never overflows.
- pc_load (Tick=1) takes priority over everything else:
  - flush the FIFO (count=0, pointers=0);
  - fetch_pc=pc_value; ir_load is suppressed that cycle.
  - From REQ without ack: go to DISCARD.
  - From REQ with ack on the same cycle: drop the data, go to REQ at pc_value.
  - From IDLE: go to REQ at pc_value.
  - From DISCARD: stay in DISCARD, with the target updated to the newest pc_value.
- ir_load = Tick & ir_ready & !empty & !pc_load (combinational).
  - ir_data and ir_pc show the head entry combinationally; they are 0 when empty.
  - Pop advances the read pointer at the edge.
- Simultaneous push and pop: count is unchanged and both pointers advance. A push into an empty FIFO is not bypassed.
- Latency:
  - pc_load at edge N gives mem_req=1 with mem_addr=pc_value from cycle N+1.
  - Ack at edge M makes the word visible at the head, with ir_load possible, at cycle M+1.
- full = (count==Depth); empty = (count==0).
- Tick=0 cycles freeze all state; ack is ignored on those cycles.

Optional Feature:
- PREFETCH_STATS_EN defined:
  - Adds output discard_count, 16 bits: a saturating count (stops at 0xFFFF) of fetched words dropped by a flush or DISCARD.
  - Counts flushed FIFO entries plus any dropped ack word.
  - Reset sets it to 0.
- Undefined: the port and its logic are absent; behaviour is otherwise identical.

Test Plan:
- Reset, then Tick=1 every cycle, ack one cycle after each req, ir_ready=0:
  - mem_addr goes 0,1,2,3;
  - then full=1 and mem_req=0;
  - ir_data=word@0, ir_pc=0.
- ir_ready=1 with continuous ack on the next cycle:
  - ir_load pops words in address order 0,1,2,…;
  - no loss or duplication; count never exceeds 4.
- pc_load with pc_value=0x200 while REQ is pending at 0x005, ack arriving 3 cycles later:
  - FIFO flushes at once; empty=1;
  - the ack word is dropped;
  - next mem_addr=0x200; first ir_pc=0x200.
- pc_load on the same cycle as an ack:
  - data is dropped, no push;
  - mem_addr=pc_value on the next cycle; ir_load=0 on the pc_load cycle.
- Tick toggling 1,0,1,0 with ack present only on Tick=0 cycles: no push and no state change occurs.
- Fetch through 0xFFF → next mem_addr=0x000; Reset=0 during REQ → mem_req=0 on the next cycle, empty=1; with PREFETCH_STATS_EN, a flush of 3 entries → discard_count=3.

Source files
------------

// File: rtl/ir_prefetch_queue.sv
// Instruction prefetch FIFO feeding the IR; fetches over req/ack, flushes on PC load.
// Define PREFETCH_STATS_EN to add the saturating discard_count output.
module ir_prefetch_queue #(
    parameter int NrOfBits = 16,
    parameter int AddrBits = 12,
    parameter int Depth    = 4
) (
    input  logic                Clock,
    input  logic                Reset,
    input  logic                Tick,
    input  logic                pc_load,
    input  logic [AddrBits-1:0] pc_value,
    output logic                mem_req,
    output logic [AddrBits-1:0] mem_addr,
    input  logic                mem_ack,
    input  logic [NrOfBits-1:0] mem_rdata,
    input  logic                ir_ready,
    output logic                ir_load,
    output logic [NrOfBits-1:0] ir_data,
    output logic [AddrBits-1:0] ir_pc,
    output logic                empty,
    output logic                full
`ifdef PREFETCH_STATS_EN
    ,
    output logic [15:0]         discard_count
`endif
);

    localparam int PW = $clog2(Depth);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(Depth);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        DISCARD = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [AddrBits-1:0] addr_q, addr_d;
    logic [AddrBits-1:0] fetch_q, fetch_d;

    logic [NrOfBits-1:0] data_mem [Depth];
    logic [AddrBits-1:0] pc_mem   [Depth];
    logic [PW-1:0]       rd_q, wr_q;
    logic [CW-1:0]       count_q;
    logic [CW-1:0]       cnt_after;

    logic push, pop, flush;

    assign empty    = (count_q == '0);
    assign full     = (count_q == DEPTH_C);
    assign mem_req  = (state_q != IDLE);
    assign mem_addr = addr_q;

    assign ir_load = Tick & ir_ready & ~empty & ~pc_load;
    assign ir_data = empty ? '0 : data_mem[rd_q];
    assign ir_pc   = empty ? '0 : pc_mem[rd_q];

    assign pop       = ir_load;
    assign flush     = Tick & pc_load;
    assign cnt_after = count_q + CW'(1) - CW'(pop);

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        fetch_d = fetch_q;
        push    = 1'b0;
        if (Tick) begin
            if (pc_load) begin
                fetch_d = pc_value;
                unique case (state_q)
                    IDLE: begin
                        state_d = REQ;
                        addr_d  = pc_value;
                    end
                    REQ: begin
                        if (mem_ack) addr_d = pc_value;
                        else         state_d = DISCARD;
                    end
                    default: ;
                endcase
            end else begin
                unique case (state_q)
                    IDLE: begin
                        if (count_q < DEPTH_C) begin
                            state_d = REQ;
                            addr_d  = fetch_q;
                        end
                    end
                    REQ: begin
                        if (mem_ack) begin
                            push    = 1'b1;
                            fetch_d = addr_q + AddrBits'(1);
                            if (cnt_after < DEPTH_C)
                                addr_d = addr_q + AddrBits'(1);
                            else
                                state_d = IDLE;
                        end
                    end
                    default: begin
                        if (mem_ack) begin
                            state_d = REQ;
                            addr_d  = fetch_q;
                        end
                    end
                endcase
            end
        end
    end

    always_ff @(posedge Clock) begin
        if (!Reset) begin
            state_q <= IDLE;
            addr_q  <= '0;
            fetch_q <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            fetch_q <= fetch_d;
        end
    end

    // Storage is not reset; the head outputs are masked while empty.
    always_ff @(posedge Clock) begin
        if (!Reset) begin
            rd_q    <= '0;
            wr_q    <= '0;
            count_q <= '0;
        end else if (flush) begin
            rd_q    <= '0;
            wr_q    <= '0;
            count_q <= '0;
        end else begin
            if (push) begin
                data_mem[wr_q] <= mem_rdata;
                pc_mem[wr_q]   <= addr_q;
                wr_q           <= wr_q + PW'(1);
            end
            if (pop) rd_q <= rd_q + PW'(1);
            count_q <= count_q + CW'(push) - CW'(pop);
        end
    end

`ifdef PREFETCH_STATS_EN
    logic [15:0] disc_q;
    logic [16:0] disc_sum;
    logic        drop;

    // An ack is lost on a flush from a busy state, or while discarding.
    assign drop = Tick & mem_ack &
                  (pc_load ? (state_q != IDLE) : (state_q == DISCARD));

    always_comb begin
        disc_sum = {1'b0, disc_q}
                 + 17'(flush ? count_q : '0)
                 + 17'(drop);
    end

    always_ff @(posedge Clock) begin
        if (!Reset)
            disc_q <= '0;
        else
            disc_q <= disc_sum[16] ? 16'hFFFF : disc_sum[15:0];
    end

    assign discard_count = disc_q;
`endif

endmodule
